// File: rtl/bsx_pkg.sv
// Shared definitions for the Satellaview stream engine.
package bsx_pkg;

    // Register offsets within one 6-byte channel group
    localparam logic [2:0] REG_PLO   = 3'd0;
    localparam logic [2:0] REG_PHI   = 3'd1;
    localparam logic [2:0] REG_STA   = 3'd2;
    localparam logic [2:0] REG_STB   = 3'd3;
    localparam logic [2:0] REG_DATA  = 3'd4;
    localparam logic [2:0] REG_LATCH = 3'd5;

    // Channel fill state
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_REQ   = 2'd1,
        CH_WAIT  = 2'd2,
        CH_READY = 2'd3
    } chan_state_t;

    // Fixed byte offsets of the page header fields
    localparam int unsigned HDR_STA  = 32'h032;
    localparam int unsigned HDR_STB  = 32'h034;
    localparam int unsigned HDR_DATA = 32'h048;

endpackage

// File: rtl/bsx_stream_chan.sv
// One stream channel: page register, fill FSM, read offsets and latch.
module bsx_stream_chan
    import bsx_pkg::*;
#(
    parameter int unsigned PAGE_W       = 10,
    parameter int unsigned OFF_W        = 9,
    parameter int unsigned PKT_LEN      = 22,
    parameter int unsigned PKT_PER_PAGE = 8,
    parameter int unsigned STB_LEN      = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic [2:0]        i_reg,
    input  logic              i_oe_rise,
    input  logic              i_oe_fall,
    input  logic              i_we_rise,
    input  logic [7:0]        i_data,
    input  logic              i_grant,
    input  logic              i_ack,
    input  logic              i_ack_ok,
    output chan_state_t       o_state,
    output logic [PAGE_W-1:0] o_page,
    output logic [OFF_W-1:0]  o_offset,
    output logic [7:0]        o_rdata
);

    localparam int unsigned BYTE_W = $clog2(PKT_LEN + 1);
    localparam int unsigned PKT_W  = $clog2(PKT_PER_PAGE + 1);
    localparam int unsigned STB_W  = $clog2(STB_LEN + 1);

    chan_state_t       r_state, w_state_nxt;
    logic              r_dirty, w_dirty_nxt;
    logic [7:0]        r_lo;
    logic [7:0]        r_latch;
    logic [PAGE_W-1:0] r_page;
    logic [BYTE_W-1:0] r_byte;
    logic [PKT_W-1:0]  r_pkt;
    logic [STB_W-1:0]  r_stb;

    logic              w_rd_stb, w_rd_data, w_rd_latch;
    logic              w_we, w_commit, w_byte_end, w_page_end;
    logic [PAGE_W-1:0] w_new_page;

    // Bus events; an OE strobe in the same cycle takes precedence over a write
    assign w_rd_stb   = i_sel && i_oe_rise && (i_reg == REG_STB)  && (r_state == CH_READY);
    assign w_rd_data  = i_sel && i_oe_rise && (i_reg == REG_DATA) && (r_state == CH_READY);
    assign w_rd_latch = i_sel && i_oe_rise && (i_reg == REG_LATCH);
    assign w_we       = i_sel && i_we_rise && !i_oe_rise && !i_oe_fall;
    assign w_commit   = w_we && (i_reg == REG_PHI);
    assign w_new_page = {i_data[PAGE_W-9:0], r_lo};
    assign w_byte_end = (r_byte == BYTE_W'(PKT_LEN - 1));
    assign w_page_end = w_rd_data && w_byte_end && (r_pkt == PKT_W'(PKT_PER_PAGE - 1));

    // Fill FSM next state: ack handling first, bus events override it
    always_comb begin
        w_state_nxt = r_state;
        w_dirty_nxt = r_dirty;
        case (r_state)
            CH_REQ:  if (i_grant) w_state_nxt = CH_WAIT;
            CH_WAIT: if (i_ack) begin
                if (r_dirty) begin
                    w_state_nxt = CH_REQ;
                    w_dirty_nxt = 1'b0;
                end else begin
                    w_state_nxt = i_ack_ok ? CH_READY : CH_IDLE;
                end
            end
            default: ;
        endcase
        if (w_page_end) w_state_nxt = CH_REQ;
        if (w_commit) begin
            if (w_new_page == '0) begin
                w_state_nxt = CH_IDLE;
                w_dirty_nxt = 1'b0;
            end else if ((r_state == CH_WAIT) && i_ack) begin
                // the ack belongs to the old page: go straight back to requesting
                w_state_nxt = CH_REQ;
                w_dirty_nxt = 1'b0;
            end else if ((r_state == CH_WAIT) || i_grant) begin
                w_dirty_nxt = 1'b1;
            end else begin
                w_state_nxt = CH_REQ;
            end
        end
    end

    // Fill FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CH_IDLE;
            r_dirty <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dirty <= w_dirty_nxt;
        end
    end

    // Page register, read offsets and status latch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lo    <= '0;
            r_page  <= '0;
            r_byte  <= '0;
            r_pkt   <= '0;
            r_stb   <= '0;
            r_latch <= '0;
        end else begin
            if (w_rd_stb) begin
                r_stb   <= (r_stb == STB_W'(STB_LEN - 1)) ? '0 : r_stb + STB_W'(1);
                r_latch <= r_latch | i_data;
            end
            if (w_rd_data) begin
                if (w_byte_end) begin
                    r_byte <= '0;
                    if (w_page_end) begin
                        r_pkt <= '0;
                        r_stb <= '0;
                    end else begin
                        r_pkt <= r_pkt + PKT_W'(1);
                    end
                end else begin
                    r_byte <= r_byte + BYTE_W'(1);
                end
            end
            if (w_rd_latch) r_latch <= '0;
            if (w_we) begin
                case (i_reg)
                    REG_PLO: r_lo <= i_data;
                    REG_PHI: begin
                        r_page <= w_new_page;
                        r_byte <= '0;
                        r_pkt  <= '0;
                        r_stb  <= '0;
                    end
                    REG_STB: r_stb <= '0;
                    REG_DATA: begin
                        r_byte <= '0;
                        r_pkt  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Page offset for the register currently addressed
    always_comb begin
        o_offset = '0;
        case (i_reg)
            REG_STA:  o_offset = OFF_W'(HDR_STA);
            REG_STB:  o_offset = OFF_W'(HDR_STB) + OFF_W'(r_stb);
            REG_DATA: o_offset = OFF_W'(HDR_DATA) + OFF_W'(r_pkt) * OFF_W'(PKT_LEN) + OFF_W'(r_byte);
            default:  o_offset = '0;
        endcase
    end

    // Directly returned register data
    always_comb begin
        o_rdata = '0;
        case (i_reg)
            REG_PLO:   o_rdata = r_lo;
            REG_PHI:   o_rdata = 8'(r_page >> 8);
            REG_LATCH: o_rdata = r_latch;
            default:   o_rdata = '0;
        endcase
    end

    assign o_state = r_state;
    assign o_page  = r_page;

endmodule

// File: rtl/bsx_stream.sv
// Satellaview stream engine top: address filter, decode, fill arbiter, output mux.
module bsx_stream
    import bsx_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter logic [7:0]  BASE_ADDR    = 8'h88,
    parameter int unsigned PAGE_W       = 10,
    parameter int unsigned OFF_W        = 9,
    parameter int unsigned PKT_LEN      = 22,
    parameter int unsigned PKT_PER_PAGE = 8,
    parameter int unsigned STB_LEN      = 20
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              use_bsx,
    input  logic [23:0]       snes_addr,
    input  logic              reg_oe_falling,
    input  logic              reg_oe_rising,
    input  logic              reg_we_rising,
    input  logic [7:0]        reg_data_in,
    output logic [7:0]        reg_data_out,
    output logic              data_ovr,
    output logic              bs_page_enable,
    output logic [PAGE_W-1:0] bs_page_out,
    output logic [OFF_W-1:0]  bs_page_offset,
    output logic              mcu_req,
    output logic [1:0]        mcu_req_ch,
    output logic [PAGE_W-1:0] mcu_req_page,
    input  logic              mcu_ack,
    input  logic              mcu_ack_ok
);

    logic [23:0]       r_addr_d1, r_addr_r;
    logic [7:0]        r_dout;
    logic [1:0]        r_req_ch;
    logic [PAGE_W-1:0] r_req_page;

    logic [7:0]        w_lo, w_rel, w_d;
    logic              w_hit;
    logic [1:0]        w_ch;
    logic [2:0]        w_reg;
    logic [NUM_CH-1:0] w_sel, w_grant;
    logic              w_any_wait, w_gnt_any;
    logic [1:0]        w_gnt_ch;
    logic [PAGE_W-1:0] w_gnt_page;
    logic [7:0]        w_rd;
    logic              w_unused_addr;

    chan_state_t       w_state [NUM_CH];
    logic [PAGE_W-1:0] w_page  [NUM_CH];
    logic [OFF_W-1:0]  w_off   [NUM_CH];
    logic [7:0]        w_rdata [NUM_CH];

    assign w_unused_addr = ^{r_addr_r[23], r_addr_r[21:16]};

    // Two-flop glitch filter: a bit is seen high only after two samples
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_addr_d1 <= '0;
            r_addr_r  <= '0;
        end else begin
            r_addr_d1 <= snes_addr;
            r_addr_r  <= snes_addr & r_addr_d1;
        end
    end

    // Address decode to channel and register index
    always_comb begin
        w_lo  = r_addr_r[7:0];
        w_rel = w_lo - BASE_ADDR;
        w_d   = '0;
        w_hit = 1'b0;
        w_ch  = '0;
        w_reg = '0;
        if (use_bsx && !r_addr_r[22] && (r_addr_r[15:8] == 8'h21) &&
            (w_lo >= BASE_ADDR) && (w_rel < 8'(6 * NUM_CH))) begin
            w_hit = 1'b1;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                w_d = w_rel - 8'(6 * c);
                if (w_d < 8'd6) begin
                    w_ch  = 2'(c);
                    w_reg = 3'(w_d);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_sel[g] = w_hit && (w_ch == 2'(g));

        bsx_stream_chan #(
            .PAGE_W       (PAGE_W),
            .OFF_W        (OFF_W),
            .PKT_LEN      (PKT_LEN),
            .PKT_PER_PAGE (PKT_PER_PAGE),
            .STB_LEN      (STB_LEN)
        ) u_chan (
            .i_clk     (clkin),
            .i_rst     (reset),
            .i_sel     (w_sel[g]),
            .i_reg     (w_reg),
            .i_oe_rise (reg_oe_rising),
            .i_oe_fall (reg_oe_falling),
            .i_we_rise (reg_we_rising),
            .i_data    (reg_data_in),
            .i_grant   (w_grant[g]),
            .i_ack     (mcu_ack),
            .i_ack_ok  (mcu_ack_ok),
            .o_state   (w_state[g]),
            .o_page    (w_page[g]),
            .o_offset  (w_off[g]),
            .o_rdata   (w_rdata[g])
        );
    end

    // Fixed-priority arbiter: one fill outstanding, lowest channel first
    always_comb begin
        w_any_wait = 1'b0;
        w_grant    = '0;
        w_gnt_any  = 1'b0;
        w_gnt_ch   = '0;
        w_gnt_page = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_state[c] == CH_WAIT) w_any_wait = 1'b1;
        end
        if (!w_any_wait) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!w_gnt_any && (w_state[c] == CH_REQ)) begin
                    w_gnt_any  = 1'b1;
                    w_grant[c] = 1'b1;
                    w_gnt_ch   = 2'(c);
                    w_gnt_page = w_page[c];
                end
            end
        end
    end

    // Request channel/page held from grant until the next grant
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_req_ch   <= '0;
            r_req_page <= '0;
        end else if (w_gnt_any) begin
            r_req_ch   <= w_gnt_ch;
            r_req_page <= w_gnt_page;
        end
    end

    // Read override mux: page memory when ready, else register data or zero
    always_comb begin
        data_ovr       = 1'b0;
        bs_page_enable = 1'b0;
        bs_page_out    = '0;
        bs_page_offset = '0;
        w_rd           = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) begin
                if ((w_reg == REG_STA) || (w_reg == REG_STB) || (w_reg == REG_DATA)) begin
                    if (w_state[c] == CH_READY) begin
                        bs_page_enable = 1'b1;
                        bs_page_out    = w_page[c];
                        bs_page_offset = w_off[c];
                    end else begin
                        data_ovr = 1'b1;
                    end
                end else begin
                    data_ovr = 1'b1;
                    w_rd     = w_rdata[c];
                end
            end
        end
    end

    // Read data captured on the OE falling strobe
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) r_dout <= '0;
        else if (reg_oe_falling) r_dout <= w_rd;
    end

    assign reg_data_out = r_dout;
    assign mcu_req      = w_any_wait;
    assign mcu_req_ch   = r_req_ch;
    assign mcu_req_page = r_req_page;

endmodule
